// File: rtl/accum_frame_ctrl.sv
// accum_frame_ctrl: frame accumulator around a 32-bit carry-bypass adder.
// Optional saturation when ACC_SAT_EN is defined (wrap when undefined).

module CarryBypassAdder #(
  parameter int N = 32
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum
);
  localparam int BW = 4;
  localparam int NB = N / BW;

  logic w_c;
  logic w_rc;
  logic w_p;

  // Ripple inside each 4-bit block, skip the block when all bits propagate
  always_comb begin
    Sum  = '0;
    w_c  = Cin;
    w_rc = 1'b0;
    w_p  = 1'b0;
    for (int b = 0; b < NB; b++) begin
      w_rc = w_c;
      w_p  = 1'b1;
      for (int i = 0; i < BW; i++) begin
        Sum[b*BW+i] = A[b*BW+i] ^ B[b*BW+i] ^ w_rc;
        w_rc = (A[b*BW+i] & B[b*BW+i]) |
               ((A[b*BW+i] ^ B[b*BW+i]) & w_rc);
        w_p  = w_p & (A[b*BW+i] ^ B[b*BW+i]);
      end
      w_c = w_p ? w_c : w_rc;
    end
  end
endmodule

module accum_frame_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_ovf
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [31:0]      r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;

  logic [31:0] w_b;
  logic [31:0] w_sum;
  logic        w_ovf_now;
  logic [31:0] w_acc_nxt;

  assign w_b = in_sub ? ~in_data : in_data;

  CarryBypassAdder #(.N(32)) u_add (
    .A   (r_acc),
    .B   (w_b),
    .Cin (in_sub),
    .Sum (w_sum)
  );

  // Signed overflow: operands agree in sign, result does not
  assign w_ovf_now = (r_acc[31] == w_b[31]) &&
                     (w_sum[31] != r_acc[31]);

`ifdef ACC_SAT_EN
  // Clamp toward the sign of the running total
  assign w_acc_nxt = !w_ovf_now ? w_sum :
                     r_acc[31] ? 32'h8000_0000 :
                                 32'h7FFF_FFFF;
`else
  assign w_acc_nxt = w_sum;
`endif

  // Frame FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= len;
            r_busy <= 1'b1;
            if (len != '0) begin
              r_state    <= S_ACCUM;
              r_in_ready <= 1'b1;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            r_acc <= w_acc_nxt;
            r_ovf <= r_ovf | w_ovf_now;
            r_cnt <= r_cnt - LEN_W'(1);
            if (r_cnt == LEN_W'(1)) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;
endmodule

// File: tb/tb_accum_frame_ctrl.sv
// tb_accum_frame_ctrl: directed + random frames vs arithmetic model.
// Follows ACC_SAT_EN the same way the design does.

module tb_accum_frame_ctrl;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sub;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_acc;
  bit          m_ovf;
  logic [31:0] fd[$];
  bit          fs[$];

  accum_frame_ctrl #(.LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  // Exact signed arithmetic; overflow = result outside int32
  function automatic void mstep(input logic [31:0] d,
                                input bit s);
    longint a;
    longint x;
    longint e;
    a = longint'($signed(m_acc));
    x = longint'($signed(d));
    e = s ? a - x : a + x;
    if (e > 64'sd2147483647 || e < -64'sd2147483648) begin
      m_ovf = 1'b1;
`ifdef ACC_SAT_EN
      m_acc = (e > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
      m_acc = e[31:0];
`endif
    end else begin
      m_acc = e[31:0];
    end
  endfunction

  task automatic frame(input int n, input bit bub,
                       input int hold, input bit pulse);
    int  i;
    int  guard;
    bit  x;
    m_acc = '0;
    m_ovf = 1'b0;
    @(negedge clk);
    start = 1'b1;
    len   = 8'(n);
    @(negedge clk);
    start = 1'b0;
    chk("in_ready_after_start", in_ready, 32'(n != 0));
    chk("busy_after_start", busy, 1);
    i = 0;
    guard = 0;
    while (i < n && guard < 500) begin
      chk("no_early_valid", out_valid, 0);
      in_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = fd[i];
      in_sub   = fs[i];
      x = in_valid && in_ready;
      @(negedge clk);
      guard++;
      if (x) begin
        mstep(fd[i], fs[i]);
        i++;
      end
    end
    in_valid = 1'b0;
    if (guard >= 500) chk("accum_timeout", 0, 1);
    chk("out_valid", out_valid, 1);
    chk("out_sum", out_sum, m_acc);
    chk("out_ovf", out_ovf, 32'(m_ovf));
    chk("in_ready_done", in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      start = pulse && (k == 1);
      len   = 8'd5;
      @(negedge clk);
      start = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_sum, m_acc);
      chk("hold_ovf", out_ovf, 32'(m_ovf));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("busy_drop", busy, 0);
    chk("in_ready_idle", in_ready, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    fd = '{32'd5, 32'd7, 32'hFFFF_FFFE};
    fs = '{0, 0, 0};
    frame(3, 0, 0, 0);
    chk("basic_sum_const", m_acc, 32'd10);

    fd = '{32'd100, 32'd250};
    fs = '{0, 1};
    frame(2, 0, 1, 0);
    chk("sub_sum_const", m_acc, 32'hFFFF_FF6A);

    fd = '{32'h7FFF_FFFF, 32'd1};
    fs = '{0, 0};
    frame(2, 0, 0, 0);
`ifdef ACC_SAT_EN
    chk("ovf_sum_const", m_acc, 32'h7FFF_FFFF);
`else
    chk("ovf_sum_const", m_acc, 32'h8000_0000);
`endif

    fd = '{32'h8000_0000, 32'd3};
    fs = '{1, 0};
    frame(2, 1, 5, 1);

    fd.delete();
    fs.delete();
    frame(0, 0, 2, 1);

    @(negedge clk);
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'd11;
    in_sub   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_sum", out_sum, 11);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_sum", out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fd = '{32'd9};
    fs = '{0};
    frame(1, 0, 0, 0);
    chk("post_reset_const", m_acc, 32'd9);

    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(0, 7);
      fd.delete();
      fs.delete();
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 4))
          0: fd.push_back(32'h7FFF_FFFF);
          1: fd.push_back(32'h8000_0000);
          2: fd.push_back(32'($urandom_range(0, 20)));
          default: fd.push_back($urandom);
        endcase
        fs.push_back(1'($urandom_range(0, 1)));
      end
      frame(n, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/accum_frame_ctrl.md
# accum_frame_ctrl

Sequential frame accumulator built around the team's 32-bit carry-bypass adder (`CarryBypassAdder`, N=32), used combinationally as its only add/subtract datapath. It sits directly downstream of the adder: it registers the adder's sum every cycle and feeds it back as operand A. The block accepts a stream of signed 32-bit samples over a valid/ready handshake, accumulates a programmed number of them per frame (each sample added or subtracted), and presents the frame total with a sticky overflow flag on a second valid/ready handshake.

## Interface
- `LEN_W`, default 8: width of the frame-length field; maximum frame is 2^LEN_W−1 samples.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle frame start request; honoured only in IDLE.
- `len` input LEN_W: samples in the frame; sampled on an accepted `start`.
- `in_valid` input 1: sample present.
- `in_ready` output 1: block can take a sample.
- `in_data` input 32: signed sample.
- `in_sub` input 1: 1 = subtract the sample, 0 = add it.
- `busy` output 1: high in ACCUM and DONE.
- `out_valid` output 1: frame result available.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output 32: signed frame total.
- `out_ovf` output 1: sticky overflow (or saturation) flag for the frame.

## Operation
- FSM states: IDLE, ACCUM, DONE. On reset: IDLE, accumulator = 0, count = 0, ovf = 0; `in_ready`, `busy`, `out_valid`, `out_ovf` = 0; `out_sum` = 0.
- IDLE: `start`=1 clears the accumulator and ovf and loads count = `len`. The FSM moves to ACCUM if `len`≠0, or directly to DONE with sum 0 and ovf 0 if `len`=0.
- ACCUM: `in_ready`=1. A transfer occurs when `in_valid`&&`in_ready`. Adder inputs are A = acc and B = `in_sub` ? ~`in_data` : `in_data`, with Cin = `in_sub`. acc ← Sum, and count decrements. On the transfer that takes count from 1 to 0, the FSM moves to DONE.
- Overflow is computed locally, without relying on the adder's carry-out: ovf_now = (A[31]==B[31]) && (Sum[31]≠A[31]). ovf ← ovf | ovf_now.
- DONE: `out_valid`=1, `out_sum`=acc, `out_ovf`=ovf. These are held stable until `out_ready`=1. On acceptance the FSM returns to IDLE and `out_valid` drops the next cycle.
- `start` outside IDLE is ignored; it is not queued. `in_valid` outside ACCUM is not consumed.
- Subtracting 0x80000000: ~B+1 overflows by definition. The ovf formula above flags it when acc sign ≥ 0. That is the required behaviour.
- Asserting `rst_n` low in any state aborts the frame immediately. No result is emitted.

## Timing
- Throughput: one sample per cycle in ACCUM. `in_ready` is a registered state decode (high for the whole ACCUM state).
- Latency: `out_valid` rises the cycle after the last sample transfer. With `len`=0, it rises the cycle after `start`.
- Minimum frame turnaround: start → ACCUM (1 cycle) + len cycles + DONE (≥1 cycle) + IDLE (1 cycle).
- The adder path is combinational within one cycle; acc, count, ovf and state are flops on `clk`.

## Configuration
- `ACC_SAT_EN` defined: when ovf_now=1, acc is loaded with 0x7FFFFFFF if A[31]=0, or 0x80000000 if A[31]=1, instead of Sum. ovf is still set. Later samples continue from the saturated value.
- `ACC_SAT_EN` undefined: acc wraps modulo 2^32 and ovf is only reported.

## Test plan
- Reset then idle: `rst_n` low → all outputs 0 and `in_ready`=0. `start` with `len`=3; samples +5, +7, −2 (add) → `out_sum`=10, `out_ovf`=0, `out_valid` the cycle after the 3rd transfer.
- Subtract path: `len`=2; add 100, sub 250 → `out_sum`=0xFFFFFF6A (−150), `out_ovf`=0.
- Overflow: `len`=2; add 0x7FFFFFFF, add 1. Without `ACC_SAT_EN` → `out_sum`=0x80000000, `out_ovf`=1. With `ACC_SAT_EN` → `out_sum`=0x7FFFFFFF, `out_ovf`=1.
- Backpressure and bubbles: `in_valid` toggling 1,0,1 over `len`=2 → only 2 transfers counted. `out_ready` held low 5 cycles → `out_valid`/`out_sum` stable. `start` pulsed during DONE → ignored.
- `len`=0: `start` → `out_valid` next cycle with `out_sum`=0 and `out_ovf`=0, and no `in_ready`.
- Reset mid-frame: `rst_n` low after 1 of 4 samples → returns to IDLE with acc=0. A new `len`=1 frame with +9 → `out_sum`=9.
